// File: rtl/matrix_stream_loader.sv
// Streams 18 A/B entries into packed row vectors for a combinational 3x3 multiplier,
// captures the product after one settle cycle and streams the nine C entries back out.
module matrix_stream_loader #(
  parameter int unsigned ENTRY_SIZE    = 5,
  parameter int unsigned RESENTRY_SIZE = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ENTRY_SIZE-1:0]      in_data,
  output logic [3*ENTRY_SIZE-1:0]    matrixAv1,
  output logic [3*ENTRY_SIZE-1:0]    matrixAv2,
  output logic [3*ENTRY_SIZE-1:0]    matrixAv3,
  output logic [3*ENTRY_SIZE-1:0]    matrixBv1,
  output logic [3*ENTRY_SIZE-1:0]    matrixBv2,
  output logic [3*ENTRY_SIZE-1:0]    matrixBv3,
  input  logic [3*RESENTRY_SIZE-1:0] matrixCv1,
  input  logic [3*RESENTRY_SIZE-1:0] matrixCv2,
  input  logic [3*RESENTRY_SIZE-1:0] matrixCv3,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RESENTRY_SIZE-1:0]   out_data,
  output logic                       busy
);

  typedef enum logic [1:0] {StLoad, StSettle, StDrain} state_e;

  state_e                   state_q, state_d;
  logic [4:0]               k_q, k_d;
  logic [3:0]               j_q, j_d;
  logic [ENTRY_SIZE-1:0]    a_q [9];
  logic [ENTRY_SIZE-1:0]    b_q [9];
  logic [RESENTRY_SIZE-1:0] c_q [9];
  logic [RESENTRY_SIZE-1:0] c_in [9];
  logic [3*RESENTRY_SIZE-1:0] c_rows [3];
  logic                     in_xfer;

  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDrain);
  assign busy      = (state_q != StLoad) || (k_q != 5'd0);
  assign out_data  = out_valid ? c_q[j_q] : '0;
  assign in_xfer   = in_valid && in_ready;

  // Column 0 sits in the MSBs of each row vector.
  assign matrixAv1 = {a_q[0], a_q[1], a_q[2]};
  assign matrixAv2 = {a_q[3], a_q[4], a_q[5]};
  assign matrixAv3 = {a_q[6], a_q[7], a_q[8]};
  assign matrixBv1 = {b_q[0], b_q[1], b_q[2]};
  assign matrixBv2 = {b_q[3], b_q[4], b_q[5]};
  assign matrixBv3 = {b_q[6], b_q[7], b_q[8]};

  assign c_rows[0] = matrixCv1;
  assign c_rows[1] = matrixCv2;
  assign c_rows[2] = matrixCv3;

  // Unpack the multiplier result rows into row-major entries.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      c_in[i] = '0;
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        c_in[3*r+c] = c_rows[r][(3-c)*RESENTRY_SIZE-1 -: RESENTRY_SIZE];
      end
    end
  end

  // Next-state logic: LOAD counts k over 18 entries, SETTLE lasts one cycle, DRAIN counts j.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    j_d     = j_q;
    unique case (state_q)
      StLoad: begin
        if (in_valid) begin
          if (k_q == 5'd17) begin
            state_d = StSettle;
            k_d     = '0;
          end else begin
            k_d = k_q + 5'd1;
          end
        end
      end
      StSettle: begin
        state_d = StDrain;
      end
      StDrain: begin
        if (out_ready) begin
          if (j_q == 4'd8) begin
            state_d = StLoad;
            j_d     = '0;
          end else begin
            j_d = j_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      k_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      j_q     <= j_d;
    end
  end

  // A/B entry registers, written in place as entries arrive; held outside LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else if (in_xfer) begin
      for (int i = 0; i < 9; i++) begin
        if (k_q == 5'(i)) begin
          a_q[i] <= in_data;
        end
        if (k_q == 5'(i + 9)) begin
          b_q[i] <= in_data;
        end
      end
    end
  end

  // Result capture at the edge closing the settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        c_q[i] <= '0;
      end
    end else if (state_q == StSettle) begin
      for (int i = 0; i < 9; i++) begin
        c_q[i] <= c_in[i];
      end
    end
  end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Bench for matrix_stream_loader: models the combinational multiplier, runs a table of
// matrix pairs through the loader and checks the drained results against a scoreboard.
module tb_matrix_stream_loader;

  localparam int unsigned EW = 5;
  localparam int unsigned RW = 9;

  typedef logic [8:0][EW-1:0] emat_t;
  typedef logic [8:0][RW-1:0] rmat_t;
  typedef struct packed {
    emat_t      a;
    emat_t      b;
    rmat_t      c;
    logic       gaps;
    logic       illegal;
    logic [1:0] rmode;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [EW-1:0]   in_data;
  logic [3*EW-1:0] matrixAv1, matrixAv2, matrixAv3;
  logic [3*EW-1:0] matrixBv1, matrixBv2, matrixBv3;
  logic [3*RW-1:0] matrixCv1, matrixCv2, matrixCv3;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   out_data;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  logic [RW-1:0] exp_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  matrix_stream_loader #(.ENTRY_SIZE(EW), .RESENTRY_SIZE(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .matrixAv1 (matrixAv1),
    .matrixAv2 (matrixAv2),
    .matrixAv3 (matrixAv3),
    .matrixBv1 (matrixBv1),
    .matrixBv2 (matrixBv2),
    .matrixBv3 (matrixBv3),
    .matrixCv1 (matrixCv1),
    .matrixCv2 (matrixCv2),
    .matrixCv3 (matrixCv3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // Combinational multiplier stand-in driven by the loader's packed rows.
  logic [3*EW-1:0] av [3];
  logic [3*EW-1:0] bv [3];
  logic [3*RW-1:0] cv [3];
  assign av[0] = matrixAv1;
  assign av[1] = matrixAv2;
  assign av[2] = matrixAv3;
  assign bv[0] = matrixBv1;
  assign bv[1] = matrixBv2;
  assign bv[2] = matrixBv3;
  assign matrixCv1 = cv[0];
  assign matrixCv2 = cv[1];
  assign matrixCv3 = cv[2];

  always_comb begin
    int acc;
    acc = 0;
    for (int r = 0; r < 3; r++) begin
      cv[r] = '0;
    end
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        acc = 0;
        for (int t = 0; t < 3; t++) begin
          acc += int'(av[r][(3-t)*EW-1 -: EW]) * int'(bv[t][(3-c)*EW-1 -: EW]);
        end
        cv[r][(3-c)*RW-1 -: RW] = RW'(acc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic rmat_t matmul(input emat_t a, input emat_t b);
    rmat_t res;
    int    acc;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        acc = 0;
        for (int t = 0; t < 3; t++) begin
          acc += int'(a[3*r+t]) * int'(b[3*t+c]);
        end
        res[3*r+c] = RW'(acc);
      end
    end
    return res;
  endfunction

  function automatic logic [3*EW-1:0] pack_row(input emat_t m, input int r);
    return {m[3*r], m[3*r+1], m[3*r+2]};
  endfunction

  // Streams one pair through the loader while a cycle-level model tracks LOAD/SETTLE/DRAIN.
  task automatic run_pair(input vec_t v);
    int            phase = 0;
    int            k = 0;
    int            j = 0;
    int            dc = 0;
    int            cyc;
    logic          hold = 1'b0;
    logic [RW-1:0] held = '0;
    logic          in_x, out_x;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (phase == 0) begin
        in_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data  = (k < 9) ? v.a[k] : v.b[k-9];
      end else begin
        in_valid = v.illegal;
        in_data  = EW'($urandom);
      end
      case (v.rmode)
        2'd0:    out_ready = 1'b1;
        2'd1:    out_ready = (dc >= 6 && dc < 11) ? 1'b0 : (dc % 2 == 1);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check("in_ready", in_ready, phase == 0);
      check("out_valid", out_valid, phase == 2);
      check("busy", busy, (phase != 0) || (k != 0));
      if (phase != 2) begin
        check("out_data_idle", out_data, 0);
      end else begin
        check("drain_av1", matrixAv1, pack_row(v.a, 0));
        check("drain_av2", matrixAv2, pack_row(v.a, 1));
        check("drain_av3", matrixAv3, pack_row(v.a, 2));
        check("drain_bv1", matrixBv1, pack_row(v.b, 0));
        check("drain_bv2", matrixBv2, pack_row(v.b, 1));
        check("drain_bv3", matrixBv3, pack_row(v.b, 2));
        if (hold) check("out_hold", out_data, held);
      end
      in_x  = in_valid && (phase == 0);
      out_x = out_ready && (phase == 2);
      if (out_x) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_extra actual=%0h required=none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
      hold = (phase == 2) && !out_x;
      held = out_data;
      @(posedge clk);
      if (in_x) begin
        k++;
        if (k == 18) begin
          phase = 1;
          k = 0;
          for (int i = 0; i < 9; i++) exp_q.push_back(v.c[i]);
        end
      end else if (phase == 1) begin
        phase = 2;
      end else if (out_x) begin
        j++;
        if (j == 9) break;
      end
      if (phase == 2) dc++;
    end
    if (cyc >= 600) begin
      checks++;
      failures++;
      $display("FAIL pair_timeout actual=%0d required=<600", cyc);
    end
    check("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int            bid [9] = '{1, 2, 3, 2, 3, 5, 3, 1, 2};
    logic [3*EW-1:0] bv1_exp;
    vec_t          fresh;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Stimulus table: directed pairs with hand-written results, then random/boundary pairs.
    for (int n = 0; n < 8; n++) begin
      vecs[n] = '0;
    end
    for (int i = 0; i < 9; i++) begin
      vecs[0].a[i] = (i % 4 == 0) ? EW'(1) : EW'(0);
      vecs[0].b[i] = EW'(bid[i]);
      vecs[0].c[i] = RW'(bid[i]);
      vecs[1].a[i] = '0;
      vecs[1].b[i] = EW'(bid[i] + 7);
      vecs[1].c[i] = '0;
      vecs[2].a[i] = EW'(1);
      vecs[2].b[i] = (i % 4 == 0) ? EW'(1) : EW'(0);
      vecs[2].c[i] = RW'(1);
      for (int n = 3; n < 7; n++) begin
        vecs[n].a[i] = EW'($urandom);
        vecs[n].b[i] = EW'($urandom);
      end
      vecs[7].a[i] = '1;
      vecs[7].b[i] = '1;
    end
    for (int n = 3; n < 8; n++) vecs[n].c = matmul(vecs[n].a, vecs[n].b);
    vecs[3].rmode   = 2'd1;
    vecs[4].gaps    = 1'b1;
    vecs[4].illegal = 1'b1;
    vecs[4].rmode   = 2'd2;
    vecs[7].rmode   = 2'd2;

    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_av1", matrixAv1, 0);
    check("rst_bv3", matrixBv3, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 8; n++) begin
      run_pair(vecs[n]);
      if (n == 0) begin
        #1;
        bv1_exp = {5'd1, 5'd2, 5'd3};
        check("identity_bv1", matrixBv1, bv1_exp);
      end
    end

    // Reset mid-load: seven entries in, asynchronous pulse between edges.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_data   = EW'(i + 1);
      out_ready = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_av1", matrixAv1, 0);
    check("mid_rst_av2", matrixAv2, 0);
    check("mid_rst_av3", matrixAv3, 0);
    check("mid_rst_bv1", matrixBv1, 0);
    check("mid_rst_bv2", matrixBv2, 0);
    check("mid_rst_bv3", matrixBv3, 0);
    #1;
    rst_n = 1'b1;

    fresh = '0;
    for (int i = 0; i < 9; i++) begin
      fresh.a[i] = EW'($urandom_range(8, 31));
      fresh.b[i] = EW'($urandom_range(8, 31));
    end
    fresh.c = matmul(fresh.a, fresh.b);
    run_pair(fresh);

    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("tail_in_ready", in_ready, 1);
    check("tail_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
